// File: rtl/ds_link_pkg.sv
// Shared types and default timing for the DS link initialisation controller.
package ds_link_pkg;

  typedef enum logic [2:0] {
    ST_ERROR_RESET = 3'd0,
    ST_ERROR_WAIT  = 3'd1,
    ST_READY       = 3'd2,
    ST_STARTED     = 3'd3,
    ST_CONNECTING  = 3'd4,
    ST_RUN         = 3'd5
  } ds_link_state_t;

  // Defaults for a 100 MHz clock
  localparam int unsigned C_T_RESET_CYC    = 640;
  localparam int unsigned C_T_WAIT_CYC     = 1280;
  localparam int unsigned C_DISCONNECT_CYC = 85;

  localparam int unsigned C_TIMER_W = 11;
  localparam int unsigned C_ERR_W   = 8;

endpackage

// File: rtl/ds_link_timer.sv
// Loadable down-counter; expired is registered and high while the count sits at zero.
module ds_link_timer
  import ds_link_pkg::*;
#(
  parameter logic [C_TIMER_W-1:0] G_RST_VAL = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [C_TIMER_W-1:0] load_val,
  output logic                 expired
);

  logic [C_TIMER_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= G_RST_VAL;
      expired <= (G_RST_VAL == '0);
    end else if (load) begin
      cnt     <= load_val;
      expired <= (load_val == '0);
    end else if (cnt != '0) begin
      cnt     <= cnt - C_TIMER_W'(1);
      expired <= (cnt == C_TIMER_W'(1));
    end
  end

endmodule

// File: rtl/ds_link_ctrl.sv
// DS link bring-up and error-recovery FSM with disconnect detection and a
// saturating fault counter.
module ds_link_ctrl
  import ds_link_pkg::*;
#(
  parameter int unsigned G_T_RESET_CYC    = C_T_RESET_CYC,
  parameter int unsigned G_T_WAIT_CYC     = C_T_WAIT_CYC,
  parameter int unsigned G_DISCONNECT_CYC = C_DISCONNECT_CYC,
  parameter int unsigned G_AUTO_START     = 1
) (
  input  logic               CLK100MHZ,
  input  logic               rst_n,
  input  logic               link_start,
  input  logic               link_disable,
  input  logic               rx_bit,
  input  logic               rx_got_null,
  input  logic               rx_got_fct,
  input  logic               rx_got_data,
  input  logic               rx_parity_err,
  input  logic               err_clr,
  output logic               rx_rst_n,
  output logic               tx_en,
  output logic               tx_fct_en,
  output logic               tx_data_en,
  output logic               link_up,
  output logic [2:0]         state_o,
  output logic [C_ERR_W-1:0] err_count
);

  // Timers are loaded with N-1 so the leaving transition lands on the N-th clock
  localparam logic [C_TIMER_W-1:0] C_RESET_LD = C_TIMER_W'(G_T_RESET_CYC - 1);
  localparam logic [C_TIMER_W-1:0] C_WAIT_LD  = C_TIMER_W'(G_T_WAIT_CYC - 1);
  localparam logic [C_TIMER_W-1:0] C_DISC_LD  = C_TIMER_W'(G_DISCONNECT_CYC - 1);

  ds_link_state_t       state;
  ds_link_state_t       state_nxt;
  logic                 armed;
  logic                 armed_nxt;
  logic                 fault;
  logic                 st_expired;
  logic                 disc_expired;
  logic                 st_load;
  logic [C_TIMER_W-1:0] st_ld_val;
  logic                 disc_load;
  logic [C_ERR_W-1:0]   err_nxt;

  ds_link_timer #(.G_RST_VAL(C_RESET_LD)) u_state_timer (
    .clk      (CLK100MHZ),
    .rst_n    (rst_n),
    .load     (st_load),
    .load_val (st_ld_val),
    .expired  (st_expired)
  );

  // Held loaded until armed, then restarted by every received bit
  ds_link_timer #(.G_RST_VAL(C_DISC_LD)) u_disc_timer (
    .clk      (CLK100MHZ),
    .rst_n    (rst_n),
    .load     (disc_load),
    .load_val (C_DISC_LD),
    .expired  (disc_expired)
  );

  // Fault detection and next-state decode; strobes are ignored in ERROR_RESET
  always_comb begin
    state_nxt = state;
    fault     = 1'b0;
    if (state != ST_ERROR_RESET) begin
      fault = rx_parity_err
            | (armed & disc_expired & ~rx_bit)
            | (rx_got_data & (state != ST_RUN))
            | (rx_got_fct & (state inside {ST_ERROR_WAIT, ST_READY, ST_STARTED}));
    end

    if (fault || link_disable) begin
      state_nxt = ST_ERROR_RESET;
    end else begin
      case (state)
        ST_ERROR_RESET: if (st_expired) state_nxt = ST_ERROR_WAIT;
        ST_ERROR_WAIT:  if (st_expired) state_nxt = ST_READY;
        ST_READY:       if (link_start || (G_AUTO_START != 0)) state_nxt = ST_STARTED;
        ST_STARTED: begin
          if (rx_got_null)     state_nxt = ST_CONNECTING;
          else if (st_expired) state_nxt = ST_ERROR_RESET;
        end
        ST_CONNECTING: begin
          if (rx_got_fct)      state_nxt = ST_RUN;
          else if (st_expired) state_nxt = ST_ERROR_RESET;
        end
        ST_RUN:         state_nxt = ST_RUN;
        default:        state_nxt = ST_ERROR_RESET;
      endcase
    end

    st_load   = (state_nxt != state) | link_disable;
    st_ld_val = (state_nxt == ST_ERROR_RESET) ? C_RESET_LD : C_WAIT_LD;

    armed_nxt = (state_nxt != ST_ERROR_RESET)
              & (armed | (rx_got_null & (state != ST_ERROR_RESET)));
    disc_load = rx_bit | ~armed;

    err_nxt = err_count;
    if (err_clr)                        err_nxt = '0;
    else if (fault && (err_count != '1)) err_nxt = err_count + C_ERR_W'(1);
  end

  // State and outputs registered together from the next-state decode
  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_ERROR_RESET;
      armed      <= 1'b0;
      rx_rst_n   <= 1'b0;
      tx_en      <= 1'b0;
      tx_fct_en  <= 1'b0;
      tx_data_en <= 1'b0;
      link_up    <= 1'b0;
      err_count  <= '0;
    end else begin
      state      <= state_nxt;
      armed      <= armed_nxt;
      rx_rst_n   <= (state_nxt != ST_ERROR_RESET);
      tx_en      <= (state_nxt inside {ST_STARTED, ST_CONNECTING, ST_RUN});
      tx_fct_en  <= (state_nxt inside {ST_CONNECTING, ST_RUN});
      tx_data_en <= (state_nxt == ST_RUN);
      link_up    <= (state_nxt == ST_RUN);
      err_count  <= err_nxt;
    end
  end

  assign state_o = 3'(state);

endmodule

// File: tb/tb_ds_link_ctrl.sv
// Directed and randomized bench for ds_link_ctrl against a cycle-counting
// reference model; timing parameters are scaled down to keep runs short.
module tb_ds_link_ctrl;

  localparam int TR   = 64;
  localparam int TW   = 128;
  localparam int DISC = 85;
  localparam int AUTO = 1;

  localparam int S_ER = 0, S_EW = 1, S_RDY = 2, S_STA = 3, S_CON = 4, S_RUN = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       link_start = 1'b0, link_disable = 1'b0;
  logic       rx_bit = 1'b0, rx_got_null = 1'b0, rx_got_fct = 1'b0;
  logic       rx_got_data = 1'b0, rx_parity_err = 1'b0, err_clr = 1'b0;
  logic       rx_rst_n, tx_en, tx_fct_en, tx_data_en, link_up;
  logic [2:0] state_o;
  logic [7:0] err_count;

  int checks = 0;
  int failures = 0;
  int bit_period = 0;
  int bit_phase = 0;
  string phase = "init";

  always #5 clk = ~clk;

  ds_link_ctrl #(
    .G_T_RESET_CYC(TR), .G_T_WAIT_CYC(TW), .G_DISCONNECT_CYC(DISC), .G_AUTO_START(AUTO)
  ) dut (
    .CLK100MHZ(clk), .rst_n(rst_n), .link_start(link_start), .link_disable(link_disable),
    .rx_bit(rx_bit), .rx_got_null(rx_got_null), .rx_got_fct(rx_got_fct),
    .rx_got_data(rx_got_data), .rx_parity_err(rx_parity_err), .err_clr(err_clr),
    .rx_rst_n(rx_rst_n), .tx_en(tx_en), .tx_fct_en(tx_fct_en), .tx_data_en(tx_data_en),
    .link_up(link_up), .state_o(state_o), .err_count(err_count)
  );

  // Reference model: time spent in the current state, clocks since last bit
  typedef struct {
    int st;
    int dwell;
    int quiet;
    bit armed;
    int err;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t mdl_next(input mdl_t c, input bit dis, input bit start,
                                    input bit bv, input bit nul, input bit fct,
                                    input bit dat, input bit par, input bit clr);
    mdl_t n = c;
    bit active = (c.st != S_ER);
    bit lost   = c.armed && (c.quiet + 1 >= DISC) && !bv;
    bit fault  = active && (par || lost || (dat && c.st != S_RUN) ||
                            (fct && c.st >= S_EW && c.st <= S_STA));
    bit tmo    = (c.dwell + 1 >= ((c.st == S_ER) ? TR : TW));
    if (fault || dis) n.st = S_ER;
    else begin
      case (c.st)
        S_ER:    if (tmo) n.st = S_EW;
        S_EW:    if (tmo) n.st = S_RDY;
        S_RDY:   if (start || AUTO != 0) n.st = S_STA;
        S_STA:   if (nul) n.st = S_CON; else if (tmo) n.st = S_ER;
        S_CON:   if (fct) n.st = S_RUN; else if (tmo) n.st = S_ER;
        default: n.st = c.st;
      endcase
    end
    n.dwell = (n.st != c.st || dis) ? 0 : c.dwell + 1;
    n.armed = (n.st != S_ER) && (c.armed || (active && nul));
    n.quiet = (bv || !c.armed) ? 0 : c.quiet + 1;
    if (clr) n.err = 0;
    else if (fault && c.err < 255) n.err = c.err + 1;
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '{S_ER, 0, 0, 1'b0, 0};
    else m <= mdl_next(m, link_disable, link_start, rx_bit, rx_got_null, rx_got_fct,
                       rx_got_data, rx_parity_err, err_clr);
  end

  task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, want);
    end
  endtask

  task automatic check_all(input string tag);
    expect_eq({tag, "/state"},   32'(state_o),    m.st);
    expect_eq({tag, "/rx_rst"},  32'(rx_rst_n),   (m.st != S_ER)  ? 1 : 0);
    expect_eq({tag, "/tx_en"},   32'(tx_en),      (m.st >= S_STA) ? 1 : 0);
    expect_eq({tag, "/fct_en"},  32'(tx_fct_en),  (m.st >= S_CON) ? 1 : 0);
    expect_eq({tag, "/data_en"}, 32'(tx_data_en), (m.st == S_RUN) ? 1 : 0);
    expect_eq({tag, "/link_up"}, 32'(link_up),    (m.st == S_RUN) ? 1 : 0);
    expect_eq({tag, "/err"},     32'(err_count),  m.err);
  endtask

  task automatic expect_zero_outputs(input string tag);
    expect_eq({tag, "/state"},   32'(state_o),    0);
    expect_eq({tag, "/rx_rst"},  32'(rx_rst_n),   0);
    expect_eq({tag, "/tx_en"},   32'(tx_en),      0);
    expect_eq({tag, "/fct_en"},  32'(tx_fct_en),  0);
    expect_eq({tag, "/data_en"}, 32'(tx_data_en), 0);
    expect_eq({tag, "/link_up"}, 32'(link_up),    0);
    expect_eq({tag, "/err"},     32'(err_count),  0);
  endtask

  // One clock: inputs set now are sampled at the next posedge, checked at the negedge
  task automatic step();
    if (bit_period != 0) begin
      bit_phase++;
      if (bit_phase >= bit_period) begin
        rx_bit = 1'b1;
        bit_phase = 0;
      end
    end
    @(negedge clk);
    if (failures < 40) check_all(phase);
    {rx_bit, rx_got_null, rx_got_fct, rx_got_data, rx_parity_err, err_clr} = '0;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_st(input int target, input int budget, input string tag);
    int n = 0;
    while (m.st != target && n < budget) begin
      step();
      n++;
    end
    expect_eq(tag, 32'(state_o), target);
  endtask

  // From ERROR_RESET/ERROR_WAIT/READY, drive a peer up to the requested state
  task automatic bring_to(input int target);
    bit_period = $urandom_range(1, 20);
    wait_st(S_STA, TR + TW + 4, "reach_started");
    steps($urandom_range(0, TW / 2));
    if (target >= S_CON) begin
      rx_got_null = 1'b1;
      step();
      expect_eq("to_connecting", 32'(state_o), S_CON);
      if (target == S_RUN) begin
        steps($urandom_range(0, TW / 2));
        rx_got_fct = 1'b1;
        step();
        expect_eq("to_run", 32'(state_o), S_RUN);
      end
    end
  endtask

  initial begin
    #(2_000_000);
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst_n = 1'b0;
    #1 expect_zero_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Idle peer: reset hold, wait dwell, auto start, then STARTED timeout
    phase = "idle";
    steps(TR - 1);  expect_eq("idle_er_hold",  32'(state_o), S_ER);
    step();         expect_eq("idle_to_ew",    32'(state_o), S_EW);
    steps(TW - 1);  expect_eq("idle_ew_hold",  32'(state_o), S_EW);
    step();         expect_eq("idle_to_ready", 32'(state_o), S_RDY);
    step();         expect_eq("idle_auto",     32'(state_o), S_STA);
    steps(TW - 1);  expect_eq("idle_sta_hold", 32'(state_o), S_STA);
    step();         expect_eq("idle_timeout",  32'(state_o), S_ER);
    expect_eq("idle_err", 32'(err_count), 0);

    // Bring-up with bits every 8 clocks
    phase = "bringup";
    bit_period = 8;
    wait_st(S_STA, TR + TW + 4, "bu_started");
    steps($urandom_range(0, 20));
    rx_got_null = 1'b1; step();
    expect_eq("bu_connecting", 32'(state_o), S_CON);
    steps(9);
    rx_got_fct = 1'b1;  step();
    expect_eq("bu_run",     32'(state_o),    S_RUN);
    expect_eq("bu_link_up", 32'(link_up),    1);
    expect_eq("bu_data_en", 32'(tx_data_en), 1);

    // Legal traffic in RUN
    phase = "run_traffic";
    for (int i = 0; i < 60; i++) begin
      bit_period  = $urandom_range(1, 40);
      rx_got_null = ($urandom_range(0, 3) == 0);
      rx_got_fct  = ($urandom_range(0, 3) == 0);
      rx_got_data = ($urandom_range(0, 3) == 0);
      step();
    end
    expect_eq("run_held", 32'(state_o), S_RUN);

    // Disconnect boundary: a bit on clock 85 saves the link, silence kills it
    phase = "disconnect";
    bit_period = 0;
    rx_bit = 1'b1; step();
    steps(DISC - 1); expect_eq("disc_pre",   32'(state_o), S_RUN);
    rx_bit = 1'b1;   step();
    expect_eq("disc_saved", 32'(state_o), S_RUN);
    steps(DISC - 1); expect_eq("disc_pre2",  32'(state_o), S_RUN);
    step();
    expect_eq("disc_fault", 32'(state_o),   S_ER);
    expect_eq("disc_err",   32'(err_count), 1);

    // Illegal characters
    phase = "illegal";
    bring_to(S_CON);
    rx_got_data = 1'b1; step();
    expect_eq("data_in_con",     32'(state_o),   S_ER);
    expect_eq("data_in_con_err", 32'(err_count), 2);
    bring_to(S_STA);
    rx_got_fct = 1'b1; step();
    expect_eq("fct_in_sta",     32'(state_o),   S_ER);
    expect_eq("fct_in_sta_err", 32'(err_count), 3);

    // Simultaneous events
    phase = "simultaneous";
    bring_to(S_CON);
    rx_parity_err = 1'b1; rx_got_fct = 1'b1; step();
    expect_eq("par_fct_con",     32'(state_o),   S_ER);
    expect_eq("par_fct_con_err", 32'(err_count), 4);
    bring_to(S_RUN);
    rx_parity_err = 1'b1; err_clr = 1'b1; step();
    expect_eq("clr_vs_fault",     32'(state_o),   S_ER);
    expect_eq("clr_vs_fault_err", 32'(err_count), 0);

    // Saturation with random fault types in ERROR_WAIT
    phase = "saturate";
    for (int i = 0; i < 260; i++) begin
      wait_st(S_EW, TR + 2, "sat_ew");
      steps($urandom_range(0, 8));
      case ($urandom_range(0, 3))
        0:       rx_parity_err = 1'b1;
        1:       rx_got_data = 1'b1;
        2:       rx_got_fct = 1'b1;
        default: begin rx_got_data = 1'b1; rx_got_null = 1'b1; end
      endcase
      step();
      if (i == 254) expect_eq("sat_at_255", 32'(err_count), 255);
    end
    expect_eq("sat_held", 32'(err_count), 255);
    err_clr = 1'b1; step();
    expect_eq("clr_only", 32'(err_count), 0);

    // Randomized sessions: random target, random strobe noise, then forced down
    phase = "random";
    for (int r = 0; r < 8; r++) begin
      bring_to($urandom_range(S_STA, S_RUN));
      for (int i = 0; i < 40; i++) begin
        rx_parity_err = ($urandom_range(0, 63) == 0);
        rx_got_data   = ($urandom_range(0, 31) == 0);
        rx_got_fct    = ($urandom_range(0, 15) == 0);
        rx_got_null   = ($urandom_range(0, 7) == 0);
        step();
      end
      link_disable = 1'b1; step();
      link_disable = 1'b0;
      expect_eq("rand_forced_down", 32'(state_o), S_ER);
    end
    err_clr = 1'b1; step();

    // link_disable holds ERROR_RESET, release restarts the full sequence
    phase = "disable";
    bring_to(S_RUN);
    link_disable = 1'b1; step();
    expect_eq("dis_enter", 32'(state_o),   S_ER);
    expect_eq("dis_err",   32'(err_count), 0);
    steps(300);
    expect_eq("dis_hold",  32'(state_o),   S_ER);
    link_disable = 1'b0;
    steps(TR - 1);  expect_eq("dis_rel_er",    32'(state_o), S_ER);
    step();         expect_eq("dis_rel_ew",    32'(state_o), S_EW);
    steps(TW - 1);  expect_eq("dis_rel_ew2",   32'(state_o), S_EW);
    step();         expect_eq("dis_rel_ready", 32'(state_o), S_RDY);

    // Asynchronous reset in CONNECTING
    phase = "rst_mid";
    bring_to(S_CON);
    #1 rst_n = 1'b0;
    #1 expect_zero_outputs("rst_async");
    @(negedge clk);
    rst_n = 1'b1;
    steps(TR - 1);  expect_eq("rst_er_hold", 32'(state_o), S_ER);
    step();         expect_eq("rst_to_ew",   32'(state_o), S_EW);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ds_link_ctrl.md
# ds_link_ctrl

Exchange-level link initialisation and error-recovery controller for one IEEE1355 DS link inside `node`. It sequences the DS receiver and transmitter through reset, wait, NULL exchange, FCT exchange and run, and detects disconnects and receive errors. On any fault it returns the link to reset. Link state and error count are exported for LEDs and for the test bench.

## Interface
Parameters:
- `G_T_RESET_CYC`, 640: ErrorReset hold time in clocks (6.4 us at 100 MHz).
- `G_T_WAIT_CYC`, 1280: ErrorWait dwell time and Started/Connecting timeout in clocks (12.8 us).
- `G_DISCONNECT_CYC`, 85: maximum clocks between received bit strobes before a disconnect is declared (850 ns).
- `G_AUTO_START`, 1: if 1, Ready advances without `link_start`.

Ports:
- `CLK100MHZ` in 1: the single clock for the block.
- `rst_n` in 1: asynchronous, active-low reset.
- `link_start` in 1: level; permits Ready→Started.
- `link_disable` in 1: level; forces ErrorReset and holds the link there.
- `rx_bit` in 1: one-cycle strobe per recovered DS bit.
- `rx_got_null` in 1: one-cycle strobe, NULL decoded.
- `rx_got_fct` in 1: one-cycle strobe, FCT decoded.
- `rx_got_data` in 1: one-cycle strobe, N-char decoded.
- `rx_parity_err` in 1: one-cycle strobe, receiver parity error.
- `rx_rst_n` out 1: active-low reset to the DS receiver.
- `tx_en` out 1: enables the transmitter (NULL fill).
- `tx_fct_en` out 1: permits FCT transmission.
- `tx_data_en` out 1: permits N-char transmission.
- `link_up` out 1: high in Run only.
- `state_o` out 3: current state encoding.
- `err_count` out 8: saturating count of fault-caused entries to ErrorReset.
- `err_clr` in 1: one-cycle strobe that clears `err_count`.

## Operation
- States and encodings: ERROR_RESET=0, ERROR_WAIT=1, READY=2, STARTED=3, CONNECTING=4, RUN=5.
- A single timer reloads on every state change.
- ERROR_RESET: `rx_rst_n`=0, all tx enables 0. After `G_T_RESET_CYC` clocks the state moves to ERROR_WAIT. While `link_disable`=1 the state stays in ERROR_RESET.
- ERROR_WAIT: receiver released. After `G_T_WAIT_CYC` clocks the state moves to READY.
- READY: moves to STARTED when `link_start`=1 or `G_AUTO_START`=1.
- STARTED: `tx_en`=1. `rx_got_null` moves the state to CONNECTING. If `G_T_WAIT_CYC` elapses first, the state moves to ERROR_RESET.
- CONNECTING: `tx_en`=1 and `tx_fct_en`=1. `rx_got_fct` moves the state to RUN. If `G_T_WAIT_CYC` elapses first, the state moves to ERROR_RESET.
- RUN: `tx_en`, `tx_fct_en`, `tx_data_en` and `link_up` are all 1.
- Faults return ERROR_WAIT through RUN to ERROR_RESET:
  - parity error;
  - disconnect;
  - `rx_got_data` in any state other than RUN;
  - `rx_got_fct` in ERROR_WAIT, READY or STARTED.
- Timeouts return to ERROR_RESET but do not count as faults.
- Disconnect detection:
  - Armed by the first `rx_got_null` after leaving ERROR_RESET.
  - The counter clears on each `rx_bit`.
  - Disconnect is flagged when the counter reaches `G_DISCONNECT_CYC`.
  - Disarmed in ERROR_RESET.
- `err_count` increments on each fault-caused entry to ERROR_RESET and saturates at 255. `err_clr` takes priority over a simultaneous increment (result is 0).
- Priority within one cycle: fault > `link_disable` > forward transition > timeout.

## Timing
- All outputs are registered. Reset values:
  - `state_o`=0 and `rx_rst_n`=0;
  - `tx_en`, `tx_fct_en`, `tx_data_en`, `link_up` all 0;
  - `err_count`=0.
- A condition sampled at edge N updates the state and every output at edge N+1. There is no extra decode latency.
- The timer expires exactly `G_T_*` clocks after state entry. The state is left on that clock.
- A disconnect is flagged on the `G_DISCONNECT_CYC`-th clock after the last `rx_bit`. An `rx_bit` on that same clock prevents it.
- Asserting `rst_n` mid-run drops all outputs asynchronously. Restart always begins at ERROR_RESET with a full `G_T_RESET_CYC` hold.
- Strobes arriving while in ERROR_RESET are ignored.

## Structure
- Package `ds_link_pkg` holds:
  - the `ds_link_state_t` enum (3 bits, encodings above);
  - default timing constants `C_T_RESET_CYC`, `C_T_WAIT_CYC`, `C_DISCONNECT_CYC` for 100 MHz.
- Sub-module `ds_link_timer` is an 11-bit loadable down-counter with `load`, `load_val` and an `expired` flag. It is instantiated twice: once as the state timer and once as the disconnect timer.
- The FSM, fault logic and error counter live in `ds_link_ctrl`.

## Test plan
- Reset release, no peer activity: ERROR_RESET for 640 clocks, ERROR_WAIT for 1280 clocks, then READY. With auto start, STARTED follows at the next clock. After a further 1280 clocks, ERROR_RESET; `err_count` stays 0.
- Bring-up: while in STARTED, pulse `rx_got_null`, then 10 clocks later `rx_got_fct`, with `rx_bit` every 8 clocks. Expect CONNECTING on the next edge after the NULL, then RUN, with `link_up`=1 and `tx_data_en`=1.
- Disconnect: in RUN, stop `rx_bit`. After exactly 85 clocks expect ERROR_RESET and `err_count`=1. If `rx_bit` arrives at clock 85, the link stays in RUN.
- Illegal characters: `rx_got_data` in CONNECTING gives ERROR_RESET with `err_count`+1. `rx_got_fct` in STARTED also gives ERROR_RESET.
- Simultaneous events: a parity error together with `rx_got_fct` in CONNECTING gives ERROR_RESET. `err_clr` together with a fault gives `err_count`=0. 256 faults leave `err_count`=255.
- `link_disable` and `rst_n`: assert `link_disable` in RUN and expect ERROR_RESET held indefinitely. Release it and expect the full 640+1280 sequence. Pulse `rst_n` low in CONNECTING and expect all outputs 0 immediately.
